// File: rtl/wb_cmd_master.sv
// Wishbone initiator: one fabric command -> one Wishbone cycle, one outstanding transfer.
// Latency: CYC/STB one edge after accept, rsp_valid one edge after ACK (or timeout abort).
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. Timeout: WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int ADDRWIDTH       = 17,
    parameter int DATAWIDTH       = 32,
    parameter int TIMEOUT_CYCLES  = 15,
    parameter int CNTR_WIDTH      = 4,
    parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [3:0]           cmd_sel_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic                 WBm_RD_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   ready_en;
    logic                   bus_q, bus_nxt;
    logic                   we_q, we_nxt;
    logic                   rd_q, rd_nxt;
    logic [ADDRWIDTH-1:0]   adr_q, adr_nxt;
    logic [3:0]             sel_q, sel_nxt;
    logic [DATAWIDTH-1:0]   dat_q, dat_nxt;
    logic                   rsp_vld_q, rsp_vld_nxt;
    logic [DATAWIDTH-1:0]   rsp_dat_q, rsp_dat_nxt;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [CNTR_WIDTH-1:0]  cnt_q, cnt_nxt;
    logic                   rsp_err_q, rsp_err_nxt;
`endif

    // ready_en keeps cmd_ready low while reset is asserted and until the first edge after release
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            bus_q     <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ready_en  <= 1'b1;
            bus_q     <= bus_nxt;
            we_q      <= we_nxt;
            rd_q      <= rd_nxt;
            adr_q     <= adr_nxt;
            sel_q     <= sel_nxt;
            dat_q     <= dat_nxt;
            rsp_vld_q <= rsp_vld_nxt;
            rsp_dat_q <= rsp_dat_nxt;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_nxt;
            rsp_err_q <= rsp_err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bus_nxt     = bus_q;
        we_nxt      = we_q;
        rd_nxt      = rd_q;
        adr_nxt     = adr_q;
        sel_nxt     = sel_q;
        dat_nxt     = dat_q;
        rsp_vld_nxt = rsp_vld_q;
        rsp_dat_nxt = rsp_dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        cnt_nxt     = cnt_q;
        rsp_err_nxt = rsp_err_q;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid_i && ready_en) begin
                    state_nxt = BUS;
                    bus_nxt   = 1'b1;
                    we_nxt    = cmd_we_i;
                    rd_nxt    = !cmd_we_i;
                    adr_nxt   = cmd_adr_i;
                    sel_nxt   = cmd_sel_i;
                    dat_nxt   = cmd_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            BUS: begin
                // ACK has priority over a timeout landing on the same edge
                if (WBm_ACK_i) begin
                    state_nxt   = RESP;
                    bus_nxt     = 1'b0;
                    we_nxt      = 1'b0;
                    rd_nxt      = 1'b0;
                    rsp_vld_nxt = 1'b1;
                    rsp_dat_nxt = rd_q ? WBm_DAT_i : '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_err_nxt = 1'b0;
                end else if (cnt_q == CNTR_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = RESP;
                    bus_nxt     = 1'b0;
                    we_nxt      = 1'b0;
                    rd_nxt      = 1'b0;
                    rsp_vld_nxt = 1'b1;
                    rsp_dat_nxt = rd_q ? TIMEOUT_READ_VALUE : '0;
                    rsp_err_nxt = 1'b1;
                end else begin
                    cnt_nxt     = cnt_q + CNTR_WIDTH'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt   = IDLE;
                    rsp_vld_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready_o    = (state == IDLE) && ready_en;
    assign rsp_valid_o    = rsp_vld_q;
    assign rsp_dat_o      = rsp_dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    assign rsp_err_o      = rsp_err_q;
`else
    assign rsp_err_o      = 1'b0;
`endif
    assign WBm_ADR_o      = adr_q;
    assign WBm_CYC_o      = bus_q;
    assign WBm_STB_o      = bus_q;
    assign WBm_WE_o       = we_q;
    assign WBm_RD_o       = rd_q;
    assign WBm_BYTE_STB_o = sel_q;
    assign WBm_DAT_o      = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: randomized commands against a wait-state slave and a transaction-level model.
module tb_wb_cmd_master;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int TMO = 15;
    localparam logic [31:0] TMO_VAL = 32'hBADFABAC;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [3:0]    cmd_sel = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic [AW-1:0] adr;
    logic          cyc, stb, we, rd, ack;
    logic [3:0]    sel;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] s_rdata = '0;

    int errors = 0;
    int checks = 0;

    // behavioural slave: acks on STB-high cycle number s_wait+1, records what it saw
    int            s_wait = 0;
    logic          s_ack = 1'b0, spur_ack = 1'b0, prev_stb = 1'b0;
    int            stb_run = 0;
    logic [AW-1:0] m_adr;
    logic [3:0]    m_sel;
    logic [DW-1:0] m_dat;
    logic          m_we, m_rd, m_stable;

    assign ack = s_ack | spur_ack;

    always @(negedge clk) begin
        if (cyc === 1'b1 && stb === 1'b1) begin
            if (!prev_stb) begin
                stb_run = 1; m_adr = adr; m_sel = sel; m_dat = dat_o;
                m_we = we; m_rd = rd; m_stable = 1'b1;
            end else begin
                stb_run++;
                if ({adr, sel, dat_o, we, rd} !== {m_adr, m_sel, m_dat, m_we, m_rd}) m_stable = 1'b0;
            end
            s_ack = (stb_run == s_wait + 1);
        end else begin
            s_ack = 1'b0;
        end
        prev_stb = (stb === 1'b1);
    end

    wb_cmd_master dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .WBm_ADR_o(adr), .WBm_CYC_o(cyc), .WBm_STB_o(stb), .WBm_WE_o(we), .WBm_RD_o(rd),
        .WBm_BYTE_STB_o(sel), .WBm_DAT_o(dat_o), .WBm_DAT_i(s_rdata), .WBm_ACK_i(ack)
    );

    // one complete transfer checked against the transaction-level expectation
    task automatic run_txn(input logic t_we, input logic [AW-1:0] t_adr, input logic [3:0] t_sel,
                           input logic [DW-1:0] t_wdat, input int w, input logic [DW-1:0] t_rdat);
        int n, lat, e_stb;
        logic e_err;
        logic [DW-1:0] e_dat;
        e_err = TO_EN && (w + 1 > TMO);
        e_stb = e_err ? TMO : w + 1;
        e_dat = t_we ? 32'h0 : (e_err ? TMO_VAL : t_rdat);
        s_wait = w; s_rdata = t_rdat;
        @(negedge clk);
        cmd_we = t_we; cmd_adr = t_adr; cmd_sel = t_sel; cmd_dat = t_wdat; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0; return;
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 0;
        while (lat < e_stb + 10) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
        end
        checks++;
        if (rsp_valid !== 1'b1 || lat != e_stb) begin
            errors++; $display("FAIL latency: rsp_valid=%b after %0d edges, required 1 after %0d", rsp_valid, lat, e_stb);
        end
        checks++;
        if (rsp_dat !== e_dat || rsp_err !== e_err) begin
            errors++; $display("FAIL rsp: dat=%h err=%b required dat=%h err=%b", rsp_dat, rsp_err, e_dat, e_err);
        end
        checks++;
        if (stb_run != e_stb || cyc !== 1'b0) begin
            errors++; $display("FAIL stb_cycles: %0d cyc=%b required %0d cyc=0", stb_run, cyc, e_stb);
        end
        checks++;
        if ({m_adr, m_sel, m_dat, m_we, m_rd, m_stable} !== {t_adr, t_sel, t_wdat, t_we, !t_we, 1'b1}) begin
            errors++;
            $display("FAIL bus_fields: adr=%h sel=%h dat=%h we=%b rd=%b stable=%b required adr=%h sel=%h dat=%h we=%b rd=%b stable=1",
                     m_adr, m_sel, m_dat, m_we, m_rd, m_stable, t_adr, t_sel, t_wdat, t_we, !t_we);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, cyc, stb, we, rd, rsp_valid, rsp_err, adr, sel, dat_o, rsp_dat} !== '0) begin
            errors++; $display("FAIL reset_vals: cmd_ready=%b cyc=%b stb=%b rsp_valid=%b adr=%h rsp_dat=%h required all 0",
                               cmd_ready, cyc, stb, rsp_valid, adr, rsp_dat);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_at_release: cmd_ready=%b required 0", cmd_ready); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: cmd_ready=%b required 1", cmd_ready); end
    endtask

    task automatic test_write();
        run_txn(1'b1, 17'h0000C, 4'hF, 32'h12345678, 0, 32'hFFFF_FFFF);
    endtask

    task automatic test_read_wait();
        run_txn(1'b0, 17'h00008, 4'hF, 32'h0, 3, 32'h000000A5);
    endtask

    task automatic test_ack_idle();
        @(negedge clk); spur_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || cyc !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++; $display("FAIL ack_idle: rsp_valid=%b cyc=%b cmd_ready=%b required 0 0 1", rsp_valid, cyc, cmd_ready);
            end
        end
        spur_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        s_wait = 0; s_rdata = 32'hCAFE0001;
        @(negedge clk);
        cmd_we = 1'b0; cmd_adr = 17'h00010; cmd_sel = 4'hF; cmd_dat = 32'h0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_we = 1'b1; cmd_adr = 17'h00014; cmd_sel = 4'h3; cmd_dat = 32'h5A5A0F0F;
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 10);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE0001) begin
            errors++; $display("FAIL bp_first: rsp_valid=%b dat=%h required 1 cafe0001", rsp_valid, rsp_dat);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE0001 || cmd_ready !== 1'b0 || cyc !== 1'b0) begin
                errors++; $display("FAIL bp_hold: rsp_valid=%b dat=%h cmd_ready=%b cyc=%b required 1 cafe0001 0 0",
                                   rsp_valid, rsp_dat, cmd_ready, cyc);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || cyc !== 1'b0) begin
            errors++; $display("FAIL bp_idle: cmd_ready=%b cyc=%b required 1 0", cmd_ready, cyc);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cyc !== 1'b1 || we !== 1'b1 || dat_o !== 32'h5A5A0F0F || sel !== 4'h3) begin
            errors++; $display("FAIL bp_second: cyc=%b we=%b dat=%h sel=%h required 1 1 5a5a0f0f 3", cyc, we, dat_o, sel);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL bp_second_rsp: valid=%b dat=%h err=%b required 1 0 0", rsp_valid, rsp_dat, rsp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        s_wait = 1000;
        @(negedge clk);
        cmd_we = 1'b0; cmd_adr = 17'h1FFFC; cmd_sel = 4'hF; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cyc, stb, rd, rsp_valid, cmd_ready, adr} !== '0) begin
            errors++; $display("FAIL reset_mid: cyc=%b stb=%b rd=%b rsp_valid=%b cmd_ready=%b adr=%h required all 0",
                               cyc, stb, rd, rsp_valid, cmd_ready, adr);
        end
        @(negedge clk); rst = 1'b0;
        run_txn(1'b0, 17'h00020, 4'hF, 32'h0, 1, 32'h600DF00D);
    endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b0, 17'h00040, 4'hF, 32'h0, 20, 32'h11111111);
        run_txn(1'b0, 17'h00044, 4'hF, 32'h0, 14, 32'h22222222);
        run_txn(1'b1, 17'h00048, 4'hC, 32'h33333333, 30, 32'h0);
    endtask
`else
    task automatic test_no_timeout();
        run_txn(1'b0, 17'h00040, 4'hF, 32'h0, 100, 32'h44444444);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), 4'($urandom), $urandom,
                    TO_EN ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 6)), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_ack_idle();
        test_backpressure();
        test_reset_mid();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
